// File: rtl/controller_clk_rst_multi_pkg.sv
// Shared types and constants for the multi-domain clock/reset sequencer:
// per-domain state encoding, STATUS field values and register word indices.
package controller_clk_rst_pkg;

  typedef enum logic [2:0] {
    DOM_OFF    = 3'd0,
    DOM_CLK_ON = 3'd1,
    DOM_RUN    = 3'd2,
    DOM_PAUSED = 3'd3,
    DOM_DRAIN  = 3'd4
  } dom_state_e;

  localparam logic [1:0] STATUS_OFF    = 2'd0;
  localparam logic [1:0] STATUS_RUN    = 2'd1;
  localparam logic [1:0] STATUS_PAUSED = 2'd2;
  localparam logic [1:0] STATUS_BUSY   = 2'd3;

  // Word indices, i.e. byte offset >> 2 (address bits [4:2]).
  localparam logic [2:0] REG_CMD_START  = 3'd0;
  localparam logic [2:0] REG_CMD_STOP   = 3'd1;
  localparam logic [2:0] REG_CMD_PAUSE  = 3'd2;
  localparam logic [2:0] REG_CMD_RESUME = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;
  localparam logic [2:0] REG_RST_HOLD   = 3'd5;

  function automatic logic [1:0] status_of(dom_state_e s);
    case (s)
      DOM_OFF:    return STATUS_OFF;
      DOM_RUN:    return STATUS_RUN;
      DOM_PAUSED: return STATUS_PAUSED;
      default:    return STATUS_BUSY;
    endcase
  endfunction

endpackage

// File: rtl/controller_clk_rst_multi_if.sv
// Flattened OBI register port of the clock/reset sequencer.
interface controller_clk_rst_multi_if;
  // Handshake: gnt equals req in the same cycle (no wait states); every granted
  // access, read or write, gets exactly one rvalid pulse in the next cycle with
  // rdata valid only during that pulse (zero otherwise). Back-to-back is legal.
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/controller_clk_rst_multi_clk_gate.sv
// Glitch-free clock gate: enable is captured while the clock is low so the
// gated output never produces a truncated high phase.
module clk_gate_cell_wrapper (
  input  logic clk_i,
  input  logic en_i,
  output logic clk_o
);

  logic en_latched;

  always_latch begin
    if (!clk_i) en_latched <= en_i;
  end

  assign clk_o = clk_i & en_latched;

endmodule

// File: rtl/controller_clk_rst_multi_domain_fsm.sv
// Per-domain sequencer: orders clock enable and reset release on start,
// drains under reset on stop, and gates only the clock on pause/resume.
module controller_domain_fsm
  import controller_clk_rst_pkg::*;
#(
  parameter int unsigned STOP_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       pause_i,
  input  logic       resume_i,
  input  logic [7:0] hold_i,
  output logic       clk_en_o,
  output logic       rst_n_o,
  output logic [1:0] status_o
);

  localparam logic [7:0] STOP_LOAD = (STOP_CYCLES == 0) ? 8'd1 : 8'(STOP_CYCLES);

  dom_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       clk_en_q, clk_en_d;
  logic       rst_n_q, rst_n_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= DOM_OFF;
      cnt_q    <= 8'd0;
      clk_en_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      rst_n_q  <= rst_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DOM_OFF: begin
        if (start_i) begin
          state_d = DOM_CLK_ON;
          // Zero hold still gives one clocked cycle under reset.
          cnt_d   = (hold_i == 8'd0) ? 8'd1 : hold_i;
        end
      end
      DOM_CLK_ON: begin
        if (cnt_q <= 8'd1) state_d = DOM_RUN;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DOM_RUN: begin
        if (stop_i) begin
          state_d = DOM_DRAIN;
          cnt_d   = STOP_LOAD;
        end else if (pause_i) begin
          state_d = DOM_PAUSED;
        end
      end
      DOM_PAUSED: begin
        if (stop_i) begin
          state_d = DOM_DRAIN;
          cnt_d   = STOP_LOAD;
        end else if (resume_i) begin
          state_d = DOM_RUN;
        end
      end
      DOM_DRAIN: begin
        if (cnt_q <= 8'd1) state_d = DOM_OFF;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = DOM_OFF;
    endcase
    // Outputs are registered from the next state so they switch with it.
    clk_en_d = (state_d == DOM_CLK_ON) || (state_d == DOM_RUN) || (state_d == DOM_DRAIN);
    rst_n_d  = (state_d == DOM_RUN) || (state_d == DOM_PAUSED);
  end

  assign clk_en_o = clk_en_q;
  assign rst_n_o  = rst_n_q;
  assign status_o = status_of(state_q);

endmodule

// File: rtl/controller_clk_rst_multi.sv
// Host-programmed clock/reset sequencer for N_DOMAINS core domains: register
// decode, RST_HOLD, OBI response flops and one gate + FSM per domain.
module controller_clk_rst_multi
  import controller_clk_rst_pkg::*;
#(
  parameter int unsigned          N_DOMAINS      = 4,
  parameter logic [7:0]           RST_HOLD_RESET = 8'd8,
  parameter int unsigned          STOP_CYCLES    = 2,
  parameter logic [N_DOMAINS-1:0] AUTOSTART_MASK = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  controller_clk_rst_multi_if.slave reg_bus,
  output logic [N_DOMAINS-1:0]      clk_core_o,
  output logic [N_DOMAINS-1:0]      rst_n_core_o
);

  logic [2:0]           reg_idx;
  logic                 wr_en, rd_en;
  logic [N_DOMAINS-1:0] cmd_bits;
  logic [N_DOMAINS-1:0] start_vec, stop_vec, pause_vec, resume_vec;
  logic [N_DOMAINS-1:0] dom_clk_en;
  logic [1:0]           dom_status [N_DOMAINS];
  logic [31:0]          status_word;
  logic [31:0]          rdata_d;
  logic [7:0]           rst_hold_q;
  logic                 first_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic                 unused_bus_bits;

  assign reg_idx  = reg_bus.addr[4:2];
  assign wr_en    = reg_bus.req & reg_bus.we;
  assign rd_en    = reg_bus.req & ~reg_bus.we;
  assign cmd_bits = reg_bus.wdata[N_DOMAINS-1:0];

  // Only address bits [4:2], be[0] and the low data bits carry meaning.
  assign unused_bus_bits = ^{reg_bus.addr[31:5], reg_bus.addr[1:0], reg_bus.be[3:1], reg_bus.wdata};

  // first_q marks the first cycle out of reset, when autostart domains launch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) first_q <= 1'b1;
    else         first_q <= 1'b0;
  end

  assign start_vec  = ((wr_en && reg_idx == REG_CMD_START) ? cmd_bits : '0)
                    | (first_q ? AUTOSTART_MASK : '0);
  assign stop_vec   = (wr_en && reg_idx == REG_CMD_STOP)   ? cmd_bits : '0;
  assign pause_vec  = (wr_en && reg_idx == REG_CMD_PAUSE)  ? cmd_bits : '0;
  assign resume_vec = (wr_en && reg_idx == REG_CMD_RESUME) ? cmd_bits : '0;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_hold_q <= RST_HOLD_RESET;
    end else if (wr_en && reg_idx == REG_RST_HOLD && reg_bus.be[0]) begin
      rst_hold_q <= reg_bus.wdata[7:0];
    end
  end

  always_comb begin
    status_word = '0;
    for (int i = 0; i < N_DOMAINS; i++) status_word[2*i +: 2] = dom_status[i];
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (reg_idx)
        REG_STATUS:   rdata_d = status_word;
        REG_RST_HOLD: rdata_d = {24'h0, rst_hold_q};
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= reg_bus.req;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_bus.gnt    = reg_bus.req;
  assign reg_bus.rvalid = rvalid_q;
  assign reg_bus.rdata  = rdata_q;

  for (genvar g = 0; g < N_DOMAINS; g++) begin : g_dom
    controller_domain_fsm #(
      .STOP_CYCLES(STOP_CYCLES)
    ) u_fsm (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .start_i  (start_vec[g]),
      .stop_i   (stop_vec[g]),
      .pause_i  (pause_vec[g]),
      .resume_i (resume_vec[g]),
      .hold_i   (rst_hold_q),
      .clk_en_o (dom_clk_en[g]),
      .rst_n_o  (rst_n_core_o[g]),
      .status_o (dom_status[g])
    );

    clk_gate_cell_wrapper u_cg (
      .clk_i (clk_i),
      .en_i  (dom_clk_en[g]),
      .clk_o (clk_core_o[g])
    );
  end

endmodule
